// File: rtl/map_port_arbiter_if.sv
// rtl/map_port_arbiter_if.sv - map port B requester/BRAM signal bundle
interface map_port_arbiter_if #(
  parameter int N_REQ  = 5,
  parameter int ADDR_W = 11,
  parameter int DATA_W = 4
);
  // read requesters
  logic [N_REQ-1:0]        rd_req;
  logic [N_REQ*ADDR_W-1:0] rd_addr;
  logic [N_REQ-1:0]        rd_gnt;
  logic [N_REQ-1:0]        rd_valid;
  logic [DATA_W-1:0]       rd_data;
  // clear (write) requester
  logic                    wr_req;
  logic [ADDR_W-1:0]       wr_addr;
  logic                    wr_gnt;
  // BRAM port B
  logic [ADDR_W-1:0]       mem_addr;
  logic                    mem_we;
  logic [DATA_W-1:0]       mem_din;
  logic [DATA_W-1:0]       mem_dout;

  // requesters plus the BRAM, seen from outside the arbiter
  modport master (
    output rd_req, rd_addr, wr_req, wr_addr, mem_dout,
    input  rd_gnt, rd_valid, rd_data, wr_gnt, mem_addr, mem_we, mem_din
  );

  // the arbiter itself
  modport slave (
    input  rd_req, rd_addr, wr_req, wr_addr, mem_dout,
    output rd_gnt, rd_valid, rd_data, wr_gnt, mem_addr, mem_we, mem_din
  );
endinterface

// File: rtl/map_port_arbiter.sv
// rtl/map_port_arbiter.sv - round-robin read / priority clear arbiter for tile map port B
module map_port_arbiter #(
  parameter int               N_REQ      = 5,
  parameter int               ADDR_W     = 11,
  parameter int               DATA_W     = 4,
  parameter logic [DATA_W-1:0] CLEAR_CODE = 4'b1000
) (
  input  logic             vga_pix_clk,
  input  logic             rst,
  map_port_arbiter_if.slave bus
);

  localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam logic [PTR_W:0]   N_REQ_W  = (PTR_W+1)'(N_REQ);
  localparam logic [PTR_W-1:0] LAST_REQ = PTR_W'(N_REQ - 1);

  // registered state
  logic [PTR_W-1:0]  ptr;
  logic [N_REQ-1:0]  rd_gnt_q;
  logic [N_REQ-1:0]  rd_valid_q;
  logic              wr_gnt_q;
  logic              mem_we_q;
  logic [ADDR_W-1:0] mem_addr_q;

  // arbitration results for this edge
  logic [N_REQ-1:0]  rd_elig;
  logic              wr_elig;
  logic              found;
  logic [PTR_W-1:0]  winner;
  logic [PTR_W-1:0]  ptr_next;
  logic [N_REQ-1:0]  gnt_next;
  logic [ADDR_W-1:0] win_addr;
  logic [PTR_W:0]    sum;
  logic [PTR_W-1:0]  cand;
  logic [ADDR_W-1:0] addr_arr [N_REQ];

  // unpack the per-requester address bus
  always_comb begin
    for (int i = 0; i < N_REQ; i++) begin
      addr_arr[i] = bus.rd_addr[i*ADDR_W +: ADDR_W];
    end
  end

  // mask in-progress grants, then scan from the pointer upward for the first eligible reader
  always_comb begin
    rd_elig = bus.rd_req & ~rd_gnt_q;
    wr_elig = bus.wr_req & ~wr_gnt_q;
    found   = 1'b0;
    winner  = '0;
    sum     = '0;
    cand    = '0;
    for (int k = 0; k < N_REQ; k++) begin
      sum = {1'b0, ptr} + (PTR_W+1)'(k);
      if (sum >= N_REQ_W) begin
        sum = sum - N_REQ_W;
      end
      cand = sum[PTR_W-1:0];
      if (!found && rd_elig[cand]) begin
        found  = 1'b1;
        winner = cand;
      end
    end
  end

  // grant vector, address and pointer advance for the selected reader
  always_comb begin
    gnt_next = {{(N_REQ-1){1'b0}}, 1'b1} << winner;
    win_addr = addr_arr[winner];
    ptr_next = (winner == LAST_REQ) ? '0 : winner + 1'b1;
  end

  // port B sequencer: clears first, then reads; rd_valid trails the grant by one cycle
  always_ff @(posedge vga_pix_clk) begin
    if (rst) begin
      ptr        <= '0;
      rd_gnt_q   <= '0;
      rd_valid_q <= '0;
      wr_gnt_q   <= 1'b0;
      mem_we_q   <= 1'b0;
      mem_addr_q <= '0;
    end else begin
      rd_valid_q <= rd_gnt_q;
      if (wr_elig) begin
        wr_gnt_q   <= 1'b1;
        mem_we_q   <= 1'b1;
        mem_addr_q <= bus.wr_addr;
        rd_gnt_q   <= '0;
      end else if (found) begin
        wr_gnt_q   <= 1'b0;
        mem_we_q   <= 1'b0;
        mem_addr_q <= win_addr;
        rd_gnt_q   <= gnt_next;
        ptr        <= ptr_next;
      end else begin
        wr_gnt_q   <= 1'b0;
        mem_we_q   <= 1'b0;
        rd_gnt_q   <= '0;
      end
    end
  end

  assign bus.rd_gnt   = rd_gnt_q;
  assign bus.rd_valid = rd_valid_q;
  assign bus.rd_data  = bus.mem_dout;
  assign bus.wr_gnt   = wr_gnt_q;
  assign bus.mem_we   = mem_we_q;
  assign bus.mem_addr = mem_addr_q;
  assign bus.mem_din  = CLEAR_CODE;

endmodule

// File: tb/tb_map_port_arbiter.sv
// tb/tb_map_port_arbiter.sv - directed bench for map_port_arbiter with a BRAM model
module tb_map_port_arbiter;

  localparam int N_REQ  = 5;
  localparam int ADDR_W = 11;
  localparam int DATA_W = 4;

  logic clk;
  logic rst;
  int   n_cmp;
  int   n_err;

  logic [DATA_W-1:0] mem [2048];

  map_port_arbiter_if #(.N_REQ(N_REQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  map_port_arbiter #(
    .N_REQ(N_REQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .CLEAR_CODE(4'b1000)
  ) dut (
    .vga_pix_clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // synchronous BRAM port B model, read-before-write
  always @(posedge clk) begin
    if (bus.mem_we) mem[bus.mem_addr] <= bus.mem_din;
    bus.mem_dout <= mem[bus.mem_addr];
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_addr(input int slot, input int a);
    bus.rd_addr[slot*ADDR_W +: ADDR_W] = ADDR_W'(a);
  endtask

  int rr_idx [6] = '{0, 1, 2, 3, 4, 0};
  int rr_val [5] = '{6, 0, 1, 2, 3};

  initial begin
    n_cmp = 0;
    n_err = 0;
    for (int i = 0; i < 2048; i++) mem[i] = DATA_W'(i % 7);
    mem[37] = 4'h3;

    // reset with everything requesting
    rst = 1'b1;
    bus.rd_req = 5'b11111;
    bus.rd_addr = '0;
    set_addr(0, 10);
    bus.wr_req = 1'b1;
    bus.wr_addr = 11'd5;
    bus.mem_dout = '0;
    tick();
    tick();
    chk("rst_rd_gnt", 32'(bus.rd_gnt), 0);
    chk("rst_rd_valid", 32'(bus.rd_valid), 0);
    chk("rst_wr_gnt", 32'(bus.wr_gnt), 0);
    chk("rst_mem_we", 32'(bus.mem_we), 0);
    chk("rst_mem_addr", 32'(bus.mem_addr), 0);
    chk("mem_din_const", 32'(bus.mem_din), 32'h8);

    rst = 1'b0;
    tick();
    chk("first_wr_gnt", 32'(bus.wr_gnt), 1);
    chk("first_mem_we", 32'(bus.mem_we), 1);
    chk("first_mem_addr", 32'(bus.mem_addr), 5);
    chk("first_rd_gnt", 32'(bus.rd_gnt), 0);
    bus.wr_req = 1'b0;
    tick();
    chk("post_rst_rd_gnt", 32'(bus.rd_gnt), 32'b00001);
    chk("post_rst_wr_gnt", 32'(bus.wr_gnt), 0);
    bus.rd_req = '0;
    tick();
    chk("post_rst_rd_valid", 32'(bus.rd_valid), 32'b00001);
    chk("post_rst_rd_data", 32'(bus.rd_data), 3);
    tick();

    // single read from requester 2
    set_addr(2, 37);
    bus.rd_req = 5'b00100;
    tick();
    chk("single_rd_gnt", 32'(bus.rd_gnt), 32'b00100);
    chk("single_mem_addr", 32'(bus.mem_addr), 37);
    chk("single_mem_we", 32'(bus.mem_we), 0);
    bus.rd_req = '0;
    tick();
    chk("single_rd_valid", 32'(bus.rd_valid), 32'b00100);
    chk("single_rd_data", 32'(bus.rd_data), 3);
    chk("single_gnt_clear", 32'(bus.rd_gnt), 0);

    // round robin with all requesters held, pointer starting from reset
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int i = 0; i < 5; i++) set_addr(i, 20 + i);
    bus.rd_req = 5'b11111;
    for (int k = 0; k < 6; k++) begin
      tick();
      chk($sformatf("rr_gnt_%0d", k), 32'(bus.rd_gnt), 32'(1) << rr_idx[k]);
      if (k == 0) begin
        chk("rr_valid_0", 32'(bus.rd_valid), 0);
      end else begin
        chk($sformatf("rr_valid_%0d", k), 32'(bus.rd_valid), 32'(1) << rr_idx[k-1]);
        chk($sformatf("rr_data_%0d", k), 32'(bus.rd_data), 32'(rr_val[rr_idx[k-1]]));
      end
    end
    bus.rd_req = '0;
    tick();
    chk("rr_tail_valid", 32'(bus.rd_valid), 32'b00001);
    chk("rr_tail_data", 32'(bus.rd_data), 6);
    chk("rr_tail_gnt", 32'(bus.rd_gnt), 0);

    // write priority, then read the cleared tile
    rst = 1'b1;
    tick();
    rst = 1'b0;
    set_addr(0, 100);
    set_addr(1, 101);
    bus.wr_addr = 11'd100;
    bus.wr_req = 1'b1;
    bus.rd_req = 5'b00011;
    tick();
    chk("wp_wr_gnt", 32'(bus.wr_gnt), 1);
    chk("wp_mem_we", 32'(bus.mem_we), 1);
    chk("wp_mem_addr", 32'(bus.mem_addr), 100);
    chk("wp_rd_gnt", 32'(bus.rd_gnt), 0);
    bus.wr_req = 1'b0;
    tick();
    chk("wp_rd_gnt0", 32'(bus.rd_gnt), 32'b00001);
    chk("wp_no_valid", 32'(bus.rd_valid), 0);
    chk("wp_we_off", 32'(bus.mem_we), 0);
    bus.rd_req = 5'b00010;
    tick();
    chk("wp_rd_gnt1", 32'(bus.rd_gnt), 32'b00010);
    chk("wp_valid0", 32'(bus.rd_valid), 32'b00001);
    chk("wp_data_clear", 32'(bus.rd_data), 32'h8);
    bus.rd_req = '0;
    tick();
    chk("wp_valid1", 32'(bus.rd_valid), 32'b00010);
    chk("wp_data1", 32'(bus.rd_data), 3);

    // requester 1 holds its request one cycle past the grant
    bus.rd_req = 5'b00010;
    tick();
    chk("mask_gnt", 32'(bus.rd_gnt), 32'b00010);
    tick();
    chk("mask_no_dup", 32'(bus.rd_gnt), 0);
    chk("mask_valid", 32'(bus.rd_valid), 32'b00010);
    chk("mask_addr_hold", 32'(bus.mem_addr), 101);
    bus.rd_req = '0;
    tick();
    chk("mask_single_valid", 32'(bus.rd_valid), 0);

    // read then clear of the same tile: read sees the old code
    set_addr(4, 200);
    bus.rd_req = 5'b10000;
    tick();
    chk("rw_rd_gnt", 32'(bus.rd_gnt), 32'b10000);
    bus.rd_req = '0;
    bus.wr_addr = 11'd200;
    bus.wr_req = 1'b1;
    tick();
    chk("rw_wr_gnt", 32'(bus.wr_gnt), 1);
    chk("rw_valid", 32'(bus.rd_valid), 32'b10000);
    chk("rw_old_data", 32'(bus.rd_data), 4);
    bus.wr_req = 1'b0;
    tick();
    chk("rw_wr_gnt_once", 32'(bus.wr_gnt), 0);

    // reset while requester 3 holds a grant
    bus.rd_req = 5'b01000;
    tick();
    chk("mid_gnt3", 32'(bus.rd_gnt), 32'b01000);
    bus.rd_req = '0;
    rst = 1'b1;
    tick();
    chk("mid_valid_drop", 32'(bus.rd_valid), 0);
    chk("mid_gnt_drop", 32'(bus.rd_gnt), 0);
    rst = 1'b0;
    bus.rd_req = 5'b11111;
    tick();
    chk("mid_ptr_zero", 32'(bus.rd_gnt), 32'b00001);
    bus.rd_req = '0;
    tick();
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
